bios_dump_tx: RTL and testbench
===============================

Name: bios_dump_tx

Overview:
- Read-back path for the bootloader RAM, in the opposite direction to UART reprogramming.
- On a start pulse, reads a range of 32-bit words through a synchronous memory read port.
- Serializes each word as four UART bytes (8N1) on a TX line, so a host can verify or back up the RAM contents.
- Sits in the programming clock domain beside the reprogramming path and drives the spare port of the RAM.

Parameters:
- ADDR_WIDTH, 12, word-address width of the memory.
- HALF_PERIOD, 433, half bit period minus one, in clk cycles. Bit time BIT_CYC = 2*(HALF_PERIOD+1) = 868 cycles.

Ports:
- clk  input  1  single clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a dump.
- startAddr  input  ADDR_WIDTH  first word address, sampled with start.
- wordCount  input  ADDR_WIDTH+1  number of words to dump, sampled with start; 0 is legal.
- busy  output  1  high from the cycle after start is accepted until the end of the last stop bit.
- done  output  1  one-cycle pulse when a dump completes.
- memEn  output  1  memory read enable.
- memAddr  output  ADDR_WIDTH  memory word address.
- memDout  input  32  read data; valid one cycle after memEn (registered-output RAM).
- uartTx  output  1  serial output; idles high.

Behaviour:
- Reset values: busy=0, done=0, memEn=0, memAddr=0, uartTx=1, state=IDLE.
- FSM states: IDLE, READ, LATCH, SEND, FINISH.
- IDLE:
  - start=1 samples startAddr and wordCount.
  - If wordCount==0, go to FINISH. Otherwise go to READ.
  - start is ignored in every state except IDLE.
- READ: memEn=1, memAddr=current address, for exactly one cycle; then go to LATCH.
- LATCH:
  - Capture memDout into the word register.
  - Byte index = 0. Increment the address modulo 2^ADDR_WIDTH (so 0xFFF wraps to 0x000).
  - Decrement the remaining count. Go to SEND.
- SEND: transmit bytes in little-endian order: word[7:0], word[15:8], word[23:16], word[31:24].
- UART frame:
  - Start bit 0, then data bits LSB first, then one stop bit 1.
  - Each bit is held exactly BIT_CYC cycles; a frame is 10*BIT_CYC cycles.
  - The four bytes of a word are sent back-to-back with no idle gap.
- After the 4th stop bit:
  - If the remaining count is nonzero, go to READ. Between words the line stays 1 for exactly 2 cycles (READ and LATCH).
  - Otherwise go to FINISH.
- FINISH: done=1 for one cycle, busy drops to 0 in the same cycle, return to IDLE.
- Latency: when start is sampled at edge E0, uartTx goes 0 (first start bit) after edge E2.
- wordCount==0: done pulses the cycle after start is accepted; busy stays 0 and no bytes are sent.
- memEn is never asserted outside READ. memAddr holds its last value otherwise.
- Reset mid-operation: the next edge forces all outputs to reset values. A partial frame is abandoned with the line high, and no done pulse is issued.

Optional Feature:
- Macro: BIOS_DUMP_CHECKSUM_EN.
- Defined: after the last word, one extra frame carries the 8-bit modular sum of all data bytes sent in this dump. The sum is cleared on start. busy stays high through this frame and done follows its stop bit.
- wordCount==0 with the macro defined: send a checksum byte of 0x00, then done.
- Undefined: no checksum frame, and no sum register is synthesized.

Test Plan:
- Reset with rst=1 for 3 cycles -> uartTx=1, busy=0, done=0, memEn=0.
- start, startAddr=0x010, wordCount=1, mem[0x010]=0x44332211:
  - one memEn pulse at addr 0x010;
  - bytes 0x11, 0x22, 0x33, 0x44 decoded with 868-cycle bits;
  - first start bit after edge E2; done once; busy low after.
- startAddr=0xFFF, wordCount=2 -> reads at 0xFFF then 0x000; exactly 2 idle cycles between the word frames; 8 bytes total.
- wordCount=0 -> done pulse the next cycle, no memEn, uartTx stays 1.
- start re-pulsed during a dump -> ignored; byte count and addresses unchanged.
- rst asserted mid-byte of the 2nd word -> uartTx=1 the next cycle, no done. A fresh start afterwards dumps correctly.
- Checksum (with BIOS_DUMP_CHECKSUM_EN), words 0x000000FF and 0x00000002 -> checksum byte 0x01.

Source files
------------

// File: rtl/bios_dump_tx.sv
// Bootloader RAM read-back: reads a word range and sends each word as four 8N1 UART bytes, LSB byte first.
// Optional BIOS_DUMP_CHECKSUM_EN appends one frame holding the 8-bit sum of all data bytes sent.
module bios_dump_tx #(
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned HALF_PERIOD = 433
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] startAddr,
  input  logic [ADDR_WIDTH:0]   wordCount,
  output logic                  busy,
  output logic                  done,
  output logic                  memEn,
  output logic [ADDR_WIDTH-1:0] memAddr,
  input  logic [31:0]           memDout,
  output logic                  uartTx
);

  localparam int unsigned BIT_CYC = 2 * (HALF_PERIOD + 1);
  localparam int unsigned CNT_W   = $clog2(BIT_CYC);
  localparam int unsigned CW      = ADDR_WIDTH + 1;

  typedef enum logic [2:0] {IDLE, READ, LATCH, SEND, FINISH} state_t;

  state_t                state_q, state_nxt;
  logic [ADDR_WIDTH-1:0] addr_q, addr_nxt;
  logic [CW-1:0]         remain_q, remain_nxt;
  logic [31:0]           word_q, word_nxt;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_nxt;
  logic [3:0]            bit_idx_q, bit_idx_nxt;
  logic [1:0]            byte_idx_q, byte_idx_nxt;
  logic                  busy_nxt, done_nxt, mem_en_nxt, tx_nxt;
  logic [ADDR_WIDTH-1:0] mem_addr_nxt;
  logic [7:0]            cur_byte_c;
  logic                  bit_last_c;
`ifdef BIOS_DUMP_CHECKSUM_EN
  logic [7:0]            sum_q, sum_nxt;
  logic                  cs_q, cs_nxt;
`endif

  assign bit_last_c = (bit_cnt_q == CNT_W'(BIT_CYC - 1));

  // Byte currently on the wire
  always_comb begin
    cur_byte_c = word_q[7:0];
    case (byte_idx_q)
      2'd1:    cur_byte_c = word_q[15:8];
      2'd2:    cur_byte_c = word_q[23:16];
      2'd3:    cur_byte_c = word_q[31:24];
      default: cur_byte_c = word_q[7:0];
    endcase
`ifdef BIOS_DUMP_CHECKSUM_EN
    if (cs_q) cur_byte_c = sum_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      remain_q   <= '0;
      word_q     <= '0;
      bit_cnt_q  <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      memEn      <= 1'b0;
      memAddr    <= '0;
      uartTx     <= 1'b1;
`ifdef BIOS_DUMP_CHECKSUM_EN
      sum_q      <= '0;
      cs_q       <= 1'b0;
`endif
    end else begin
      state_q    <= state_nxt;
      addr_q     <= addr_nxt;
      remain_q   <= remain_nxt;
      word_q     <= word_nxt;
      bit_cnt_q  <= bit_cnt_nxt;
      bit_idx_q  <= bit_idx_nxt;
      byte_idx_q <= byte_idx_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      memEn      <= mem_en_nxt;
      memAddr    <= mem_addr_nxt;
      uartTx     <= tx_nxt;
`ifdef BIOS_DUMP_CHECKSUM_EN
      sum_q      <= sum_nxt;
      cs_q       <= cs_nxt;
`endif
    end
  end

  // Next state and next registered outputs; uartTx reflects the bit being held
  always_comb begin
    state_nxt    = state_q;
    addr_nxt     = addr_q;
    remain_nxt   = remain_q;
    word_nxt     = word_q;
    bit_cnt_nxt  = bit_cnt_q;
    bit_idx_nxt  = bit_idx_q;
    byte_idx_nxt = byte_idx_q;
    busy_nxt     = busy;
    done_nxt     = 1'b0;
    mem_en_nxt   = 1'b0;
    mem_addr_nxt = memAddr;
    tx_nxt       = uartTx;
`ifdef BIOS_DUMP_CHECKSUM_EN
    sum_nxt      = sum_q;
    cs_nxt       = cs_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          addr_nxt   = startAddr;
          remain_nxt = wordCount;
`ifdef BIOS_DUMP_CHECKSUM_EN
          sum_nxt    = '0;
          cs_nxt     = 1'b0;
`endif
          if (wordCount == '0) begin
`ifdef BIOS_DUMP_CHECKSUM_EN
            state_nxt   = SEND;
            cs_nxt      = 1'b1;
            busy_nxt    = 1'b1;
            bit_cnt_nxt = '0;
            bit_idx_nxt = '0;
            tx_nxt      = 1'b0;
`else
            state_nxt = FINISH;
            done_nxt  = 1'b1;
`endif
          end else begin
            state_nxt    = READ;
            busy_nxt     = 1'b1;
            mem_en_nxt   = 1'b1;
            mem_addr_nxt = startAddr;
          end
        end
      end
      READ: state_nxt = LATCH;
      LATCH: begin
        word_nxt     = memDout;
        addr_nxt     = addr_q + ADDR_WIDTH'(1);
        remain_nxt   = remain_q - CW'(1);
        byte_idx_nxt = '0;
        bit_idx_nxt  = '0;
        bit_cnt_nxt  = '0;
        tx_nxt       = 1'b0;
        state_nxt    = SEND;
`ifdef BIOS_DUMP_CHECKSUM_EN
        sum_nxt = sum_q + memDout[7:0] + memDout[15:8] + memDout[23:16] + memDout[31:24];
`endif
      end
      SEND: begin
        if (!bit_last_c) begin
          bit_cnt_nxt = bit_cnt_q + CNT_W'(1);
        end else begin
          bit_cnt_nxt = '0;
          if (bit_idx_q != 4'd9) begin
            bit_idx_nxt = bit_idx_q + 4'd1;
            tx_nxt      = (bit_idx_q < 4'd8) ? cur_byte_c[bit_idx_q[2:0]] : 1'b1;
          end else begin
`ifdef BIOS_DUMP_CHECKSUM_EN
            if (cs_q) begin
              state_nxt = FINISH;
              done_nxt  = 1'b1;
              busy_nxt  = 1'b0;
            end else if (byte_idx_q != 2'd3) begin
              byte_idx_nxt = byte_idx_q + 2'd1;
              bit_idx_nxt  = '0;
              tx_nxt       = 1'b0;
            end else if (remain_q != '0) begin
              state_nxt    = READ;
              mem_en_nxt   = 1'b1;
              mem_addr_nxt = addr_q;
            end else begin
              cs_nxt      = 1'b1;
              bit_idx_nxt = '0;
              tx_nxt      = 1'b0;
            end
`else
            if (byte_idx_q != 2'd3) begin
              byte_idx_nxt = byte_idx_q + 2'd1;
              bit_idx_nxt  = '0;
              tx_nxt       = 1'b0;
            end else if (remain_q != '0) begin
              state_nxt    = READ;
              mem_en_nxt   = 1'b1;
              mem_addr_nxt = addr_q;
            end else begin
              state_nxt = FINISH;
              done_nxt  = 1'b1;
              busy_nxt  = 1'b0;
            end
`endif
          end
        end
      end
      FINISH: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bios_dump_tx.sv
// Directed bench for bios_dump_tx: registered-output RAM model, UART frame decoder, per-scenario tasks.
module tb_bios_dump_tx;

  localparam int AW = 12;
  localparam int HP = 7;
  localparam int BC = 2 * (HP + 1);
`ifdef BIOS_DUMP_CHECKSUM_EN
  localparam int CSB = 1;
`else
  localparam int CSB = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] startAddr = '0;
  logic [AW:0]   wordCount = '0;
  logic          busy, done, memEn, uartTx;
  logic [AW-1:0] memAddr;
  logic [31:0]   memDout = '0;
  logic [31:0]   mem [0:4095];

  int n_checks = 0;
  int n_fail = 0;

  bios_dump_tx #(.ADDR_WIDTH(AW), .HALF_PERIOD(HP)) dut (
    .clk(clk), .rst(rst), .start(start), .startAddr(startAddr), .wordCount(wordCount),
    .busy(busy), .done(done), .memEn(memEn), .memAddr(memAddr), .memDout(memDout),
    .uartTx(uartTx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (memEn) memDout <= mem[memAddr];

  // Monitors: read addresses, done pulses, and a UART decoder sampling mid-bit
  int            cyc = 0;
  int            t0 = 0;
  int            off = 0;
  bit            active = 1'b0;
  int            fr_err = 0;
  int            done_cnt = 0;
  logic [7:0]    shreg = '0;
  logic [7:0]    bytes_q[$];
  int            starts_q[$];
  logic [AW-1:0] rd_q[$];

  always @(negedge clk) begin
    cyc++;
    if (memEn === 1'b1) rd_q.push_back(memAddr);
    if (done === 1'b1) done_cnt++;
    if (rst) begin
      active = 1'b0;
    end else if (!active) begin
      if (uartTx === 1'b0) begin
        active = 1'b1;
        t0 = cyc;
        starts_q.push_back(cyc);
      end
    end else begin
      off = cyc - t0;
      if (off == BC / 2 && uartTx !== 1'b0) fr_err++;
      for (int k = 1; k <= 8; k++) if (off == k * BC + BC / 2) shreg[k-1] = uartTx;
      if (off == 9 * BC + BC / 2) begin
        if (uartTx !== 1'b1) fr_err++;
        bytes_q.push_back(shreg);
        active = 1'b0;
      end
    end
  end

  task automatic clear_mon();
    bytes_q.delete(); starts_q.delete(); rd_q.delete();
    done_cnt = 0; fr_err = 0;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_start(input logic [AW-1:0] a, input logic [AW:0] wc);
    startAddr = a; wordCount = wc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output bit ok, output logic busy_seen);
    ok = 1'b0; busy_seen = 1'bx;
    for (int i = 0; i < limit && !ok; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin ok = 1'b1; busy_seen = busy; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cycles(3);
    n_checks++; if (uartTx !== 1'b1) begin n_fail++; $display("FAIL reset_tx got %b want 1", uartTx); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_checks++; if (memEn !== 1'b0) begin n_fail++; $display("FAIL reset_memen got %b want 0", memEn); end
    n_checks++; if (memAddr !== 12'h000) begin n_fail++; $display("FAIL reset_addr got %h want 000", memAddr); end
    rst = 1'b0;
    cycles(2);
  endtask

  task automatic test_single_word();
    logic [7:0] exp [4];
    bit ok; logic bs;
    exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33; exp[3] = 8'h44;
    clear_mon();
    mem[12'h010] = 32'h44332211;
    pulse_start(12'h010, 13'd1);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL sw_busy_e0 got %b want 1", busy); end
    n_checks++; if (memEn !== 1'b1 || memAddr !== 12'h010) begin n_fail++; $display("FAIL sw_read_e0 got en=%b addr=%h want en=1 addr=010", memEn, memAddr); end
    n_checks++; if (uartTx !== 1'b1) begin n_fail++; $display("FAIL sw_tx_e0 got %b want 1", uartTx); end
    cycles(1);
    n_checks++; if (memEn !== 1'b0 || uartTx !== 1'b1) begin n_fail++; $display("FAIL sw_e1 got en=%b tx=%b want en=0 tx=1", memEn, uartTx); end
    cycles(1);
    n_checks++; if (uartTx !== 1'b0) begin n_fail++; $display("FAIL sw_startbit_e2 got %b want 0", uartTx); end
    wait_done(60 * BC, ok, bs);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL sw_done_timeout got none want done pulse"); end
    n_checks++; if (bs !== 1'b0) begin n_fail++; $display("FAIL sw_busy_at_done got %b want 0", bs); end
    cycles(2);
    n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL sw_after got done=%b busy=%b want 0 0", done, busy); end
    n_checks++; if (rd_q.size() != 1 || rd_q[0] !== 12'h010) begin n_fail++; $display("FAIL sw_reads got n=%0d want 1 at 010", rd_q.size()); end
    n_checks++; if (bytes_q.size() != 4 + CSB) begin n_fail++; $display("FAIL sw_nbytes got %0d want %0d", bytes_q.size(), 4 + CSB); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (bytes_q[i] !== exp[i]) begin n_fail++; $display("FAIL sw_byte%0d got %h want %h", i, bytes_q[i], exp[i]); end
    end
    n_checks++; if (starts_q[1] - starts_q[0] != 10 * BC) begin n_fail++; $display("FAIL sw_frame_len got %0d want %0d", starts_q[1] - starts_q[0], 10 * BC); end
    n_checks++; if (done_cnt != 1 || fr_err != 0) begin n_fail++; $display("FAIL sw_done_cnt_framing got done=%0d ferr=%0d want 1 0", done_cnt, fr_err); end
  endtask

  task automatic test_wrap();
    logic [7:0] exp [8];
    bit ok; logic bs;
    exp[0] = 8'hD4; exp[1] = 8'hC3; exp[2] = 8'hB2; exp[3] = 8'hA1;
    exp[4] = 8'h3C; exp[5] = 8'h2D; exp[6] = 8'h1E; exp[7] = 8'h0F;
    clear_mon();
    mem[12'hFFF] = 32'hA1B2C3D4;
    mem[12'h000] = 32'h0F1E2D3C;
    pulse_start(12'hFFF, 13'd2);
    wait_done(120 * BC, ok, bs);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL wrap_done_timeout got none want done pulse"); end
    cycles(2);
    n_checks++; if (rd_q.size() != 2 || rd_q[0] !== 12'hFFF || rd_q[1] !== 12'h000) begin n_fail++; $display("FAIL wrap_reads got n=%0d want FFF,000", rd_q.size()); end
    n_checks++; if (bytes_q.size() != 8 + CSB) begin n_fail++; $display("FAIL wrap_nbytes got %0d want %0d", bytes_q.size(), 8 + CSB); end
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (bytes_q[i] !== exp[i]) begin n_fail++; $display("FAIL wrap_byte%0d got %h want %h", i, bytes_q[i], exp[i]); end
    end
    n_checks++; if (starts_q[3] - starts_q[2] != 10 * BC) begin n_fail++; $display("FAIL wrap_in_word got %0d want %0d", starts_q[3] - starts_q[2], 10 * BC); end
    n_checks++; if (starts_q[4] - starts_q[3] != 10 * BC + 2) begin n_fail++; $display("FAIL wrap_word_gap got %0d want %0d", starts_q[4] - starts_q[3], 10 * BC + 2); end
    n_checks++; if (done_cnt != 1 || fr_err != 0) begin n_fail++; $display("FAIL wrap_done_framing got done=%0d ferr=%0d want 1 0", done_cnt, fr_err); end
  endtask

  task automatic test_zero();
    clear_mon();
    pulse_start(12'h123, 13'd0);
`ifdef BIOS_DUMP_CHECKSUM_EN
    begin
      bit ok; logic bs;
      wait_done(30 * BC, ok, bs);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL zero_done_timeout got none want done pulse"); end
      cycles(2);
      n_checks++; if (bytes_q.size() != 1 || bytes_q[0] !== 8'h00) begin n_fail++; $display("FAIL zero_cs got n=%0d want one 00 byte", bytes_q.size()); end
    end
`else
    n_checks++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL zero_done got done=%b busy=%b want 1 0", done, busy); end
    cycles(1);
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL zero_done_width got %b want 0", done); end
    cycles(2 * BC);
    n_checks++; if (starts_q.size() != 0 || uartTx !== 1'b1) begin n_fail++; $display("FAIL zero_tx got starts=%0d tx=%b want 0 1", starts_q.size(), uartTx); end
`endif
    n_checks++; if (rd_q.size() != 0 || done_cnt != 1) begin n_fail++; $display("FAIL zero_reads got reads=%0d done=%0d want 0 1", rd_q.size(), done_cnt); end
  endtask

  task automatic test_restart_ignored();
    logic [7:0] exp [4];
    bit ok; logic bs;
    exp[0] = 8'h21; exp[1] = 8'h43; exp[2] = 8'h65; exp[3] = 8'h87;
    clear_mon();
    mem[12'h020] = 32'h87654321;
    mem[12'h100] = 32'hFFFFFFFF;
    pulse_start(12'h020, 13'd1);
    cycles(3 * BC);
    pulse_start(12'h100, 13'd3);
    wait_done(60 * BC, ok, bs);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rs_done_timeout got none want done pulse"); end
    cycles(4 * BC);
    n_checks++; if (rd_q.size() != 1 || rd_q[0] !== 12'h020) begin n_fail++; $display("FAIL rs_reads got n=%0d want 1 at 020", rd_q.size()); end
    n_checks++; if (bytes_q.size() != 4 + CSB) begin n_fail++; $display("FAIL rs_nbytes got %0d want %0d", bytes_q.size(), 4 + CSB); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (bytes_q[i] !== exp[i]) begin n_fail++; $display("FAIL rs_byte%0d got %h want %h", i, bytes_q[i], exp[i]); end
    end
    n_checks++; if (done_cnt != 1 || busy !== 1'b0) begin n_fail++; $display("FAIL rs_done got done=%0d busy=%b want 1 0", done_cnt, busy); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp [4];
    bit ok; logic bs;
    int guard;
    exp[0] = 8'hEF; exp[1] = 8'hBE; exp[2] = 8'hAD; exp[3] = 8'hDE;
    clear_mon();
    mem[12'h030] = 32'h01020304;
    mem[12'h031] = 32'h00000000;
    pulse_start(12'h030, 13'd2);
    guard = 0;
    while (rd_q.size() < 2 && guard < 80 * BC) begin cycles(1); guard++; end
    guard = 0;
    while (uartTx !== 1'b0 && guard < 10) begin cycles(1); guard++; end
    cycles(2 * BC);
    n_checks++; if (uartTx !== 1'b0 || rd_q.size() != 2) begin n_fail++; $display("FAIL rm_midbyte got tx=%b reads=%0d want 0 2", uartTx, rd_q.size()); end
    rst = 1'b1;
    cycles(1);
    n_checks++; if (uartTx !== 1'b1 || busy !== 1'b0 || memEn !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL rm_reset got tx=%b busy=%b en=%b done=%b want 1 0 0 0", uartTx, busy, memEn, done); end
    rst = 1'b0;
    cycles(20 * BC);
    n_checks++; if (done_cnt != 0 || uartTx !== 1'b1) begin n_fail++; $display("FAIL rm_no_done got done=%0d tx=%b want 0 1", done_cnt, uartTx); end
    n_checks++; if (bytes_q.size() != 4) begin n_fail++; $display("FAIL rm_nbytes got %0d want 4", bytes_q.size()); end
    clear_mon();
    mem[12'h040] = 32'hDEADBEEF;
    pulse_start(12'h040, 13'd1);
    wait_done(60 * BC, ok, bs);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rm_fresh_timeout got none want done pulse"); end
    cycles(2);
    n_checks++; if (rd_q.size() != 1 || rd_q[0] !== 12'h040) begin n_fail++; $display("FAIL rm_fresh_reads got n=%0d want 1 at 040", rd_q.size()); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (bytes_q[i] !== exp[i]) begin n_fail++; $display("FAIL rm_fresh_byte%0d got %h want %h", i, bytes_q[i], exp[i]); end
    end
  endtask

`ifdef BIOS_DUMP_CHECKSUM_EN
  task automatic test_checksum();
    bit ok; logic bs;
    clear_mon();
    mem[12'h050] = 32'h000000FF;
    mem[12'h051] = 32'h00000002;
    pulse_start(12'h050, 13'd2);
    wait_done(120 * BC, ok, bs);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL cs_done_timeout got none want done pulse"); end
    cycles(2);
    n_checks++; if (bytes_q.size() != 9) begin n_fail++; $display("FAIL cs_nbytes got %0d want 9", bytes_q.size()); end
    n_checks++; if (bytes_q[8] !== 8'h01) begin n_fail++; $display("FAIL cs_sum got %h want 01", bytes_q[8]); end
  endtask
`endif

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    @(posedge clk); #1;
    test_reset();
    test_single_word();
    test_wrap();
    test_zero();
    test_restart_ignored();
    test_reset_mid();
`ifdef BIOS_DUMP_CHECKSUM_EN
    test_checksum();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
